// File: rtl/alu_input_sequencer.sv
// Steps Enter/Undo button presses through A -> B -> opcode -> result, emitting one-cycle load strobes.
// Latency: press stable from cycle 0 gives strobe in cycle DEBOUNCE_CYCLES+3; no backpressure, strobes are fire-and-forget.
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       undo,
    output logic       load_A,
    output logic       load_B,
    output logic       load_Op,
    output logic       updateRes,
    output logic       display_sel,
    output logic [3:0] state_leds
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'd0,
        S_WAIT_B  = 2'd1,
        S_WAIT_OP = 2'd2,
        S_SHOW    = 2'd3
    } state_t;

    // Index 0 is Enter, index 1 is Undo.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    prev_q, prev_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    press;
    logic          enter_p;
    logic          undo_p;

    state_t        state_q, state_d;
    logic          load_a_q, load_a_d;
    logic          load_b_q, load_b_d;
    logic          load_op_q, load_op_d;
    logic          update_res_q, update_res_d;
    logic          display_sel_q, display_sel_d;
    logic [3:0]    state_leds_q, state_leds_d;

    assign btn_raw = {undo, enter};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync1_d[i] = btn_raw[i];
            sync2_d[i] = sync1_q[i];
            prev_d[i]  = deb_q[i];
            deb_d[i]   = deb_q[i];
            cnt_d[i]   = '0;
            // Counter only runs while the synced level disagrees; any agreeing sample restarts it.
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press   = deb_q & ~prev_q;
    assign enter_p = press[0];
    assign undo_p  = press[1];

    always_comb begin
        state_d      = state_q;
        load_a_d     = 1'b0;
        load_b_d     = 1'b0;
        load_op_d    = 1'b0;
        // Result is captured one cycle after the opcode so the ALU output has settled.
        update_res_d = load_op_q;
        if (enter_p && !undo_p) begin
            unique case (state_q)
                S_WAIT_A:  begin state_d = S_WAIT_B;  load_a_d  = 1'b1; end
                S_WAIT_B:  begin state_d = S_WAIT_OP; load_b_d  = 1'b1; end
                S_WAIT_OP: begin state_d = S_SHOW;    load_op_d = 1'b1; end
                S_SHOW:    state_d = S_WAIT_A;
            endcase
        end else if (undo_p && !enter_p) begin
            unique case (state_q)
                S_WAIT_A:  state_d = S_WAIT_A;
                S_WAIT_B:  state_d = S_WAIT_A;
                S_WAIT_OP: state_d = S_WAIT_B;
                S_SHOW:    state_d = S_WAIT_OP;
            endcase
        end
        display_sel_d = (state_d == S_SHOW);
        unique case (state_d)
            S_WAIT_A:  state_leds_d = 4'b0001;
            S_WAIT_B:  state_leds_d = 4'b0010;
            S_WAIT_OP: state_leds_d = 4'b0100;
            S_SHOW:    state_leds_d = 4'b1000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_WAIT_A;
            load_a_q      <= 1'b0;
            load_b_q      <= 1'b0;
            load_op_q     <= 1'b0;
            update_res_q  <= 1'b0;
            display_sel_q <= 1'b0;
            state_leds_q  <= 4'b0001;
        end else begin
            state_q       <= state_d;
            load_a_q      <= load_a_d;
            load_b_q      <= load_b_d;
            load_op_q     <= load_op_d;
            update_res_q  <= update_res_d;
            display_sel_q <= display_sel_d;
            state_leds_q  <= state_leds_d;
        end
    end

    assign load_A      = load_a_q;
    assign load_B      = load_b_q;
    assign load_Op     = load_op_q;
    assign updateRes   = update_res_q;
    assign display_sel = display_sel_q;
    assign state_leds  = state_leds_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer with a short debounce window.
module tb_alu_input_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter = 1'b0;
    logic       undo = 1'b0;
    logic       load_A, load_B, load_Op, updateRes, display_sel;
    logic [3:0] state_leds;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .enter       (enter),
        .undo        (undo),
        .load_A      (load_A),
        .load_B      (load_B),
        .load_Op     (load_Op),
        .updateRes   (updateRes),
        .display_sel (display_sel),
        .state_leds  (state_leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last N synchronised samples all differ
    // from it; a press is the cycle after a 0->1 acceptance; the walk through the four steps
    // is a plain state number with the strobe each transition owns.
    logic [N-1:0] m_we, m_wu;
    logic m_s1e, m_s2e, m_s1u, m_s2u, m_de, m_du, m_pe, m_pu, m_e, m_u;
    int   m_st;
    logic x_la, x_lb, x_lop, x_upd, x_disp;
    logic [3:0] x_leds;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_we = '0; m_wu = '0;
            {m_s1e, m_s2e, m_s1u, m_s2u, m_de, m_du, m_pe, m_pu} = '0;
            m_st = 0;
            {x_la, x_lb, x_lop, x_upd, x_disp} = '0;
            x_leds = 4'b0001;
        end else begin
            m_e = m_pe;
            m_u = m_pu;
            x_upd = x_lop;
            x_la = 1'b0; x_lb = 1'b0; x_lop = 1'b0;
            if (m_e && !m_u) begin
                case (m_st)
                    0: begin m_st = 1; x_la = 1'b1; end
                    1: begin m_st = 2; x_lb = 1'b1; end
                    2: begin m_st = 3; x_lop = 1'b1; end
                    default: m_st = 0;
                endcase
            end else if (m_u && !m_e) begin
                if (m_st > 0) m_st = m_st - 1;
            end
            x_leds = 4'b0001 << m_st;
            x_disp = (m_st == 3);
            m_pe = 1'b0; m_pu = 1'b0;
            m_we = {m_we[N-2:0], m_s2e};
            m_wu = {m_wu[N-2:0], m_s2u};
            if (m_we == {N{~m_de}}) begin m_de = ~m_de; m_pe = m_de; end
            if (m_wu == {N{~m_du}}) begin m_du = ~m_du; m_pu = m_du; end
            m_s2e = m_s1e; m_s1e = enter;
            m_s2u = m_s1u; m_s1u = undo;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en)
            chk("cycle_outputs", {23'd0, load_A, load_B, load_Op, updateRes, display_sel, state_leds},
                {23'd0, x_la, x_lb, x_lop, x_upd, x_disp, x_leds});
    end

    int n_la = 0, n_lb = 0, n_lop = 0, n_upd = 0, cyc = 0, lop_cyc = -100, upd_cyc = -200;
    initial forever begin
        @(negedge clk);
        if (load_A === 1'b1) n_la++;
        if (load_B === 1'b1) n_lb++;
        if (load_Op === 1'b1) begin n_lop++; lop_cyc = cyc; end
        if (updateRes === 1'b1) begin n_upd++; upd_cyc = cyc; end
        cyc++;
    end

    function automatic int total_strobes();
        return n_la + n_lb + n_lop + n_upd;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enter = 1'b0; undo = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic e, input logic u);
        enter = e; undo = u;
        tick(10);
        enter = 1'b0; undo = 1'b0;
        tick(10);
    endtask

    int base, base_la, base_lb, base_lop, base_upd, off, npulse;

    initial begin
        tick(2);
        cmp_en = 1'b1;
        chk("reset_leds", state_leds, 4'b0001);
        chk("reset_strobes_disp", {load_A, load_B, load_Op, updateRes, display_sel}, 5'b0);
        rst_n = 1'b1;

        // 1: enter held from cycle 10 for 20 cycles
        do_reset();
        tick(10);
        enter = 1'b1;
        npulse = 0; off = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (load_A === 1'b1) begin npulse++; off = k; end
        end
        tick(1);
        enter = 1'b0;
        tick(10);
        chk("s1_load_a_pulses", npulse, 1);
        chk("s1_load_a_cycle", 10 + off, 17);
        chk("s1_leds", state_leds, 4'b0010);

        // 2: full A -> B -> Op -> show, then back to A
        do_reset();
        base_la = n_la; base_lb = n_lb; base_lop = n_lop; base_upd = n_upd;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("s2_leds_show", state_leds, 4'b1000);
        chk("s2_disp_show", display_sel, 1'b1);
        chk("s2_load_a_cnt", n_la - base_la, 1);
        chk("s2_load_b_cnt", n_lb - base_lb, 1);
        chk("s2_load_op_cnt", n_lop - base_lop, 1);
        chk("s2_update_cnt", n_upd - base_upd, 1);
        chk("s2_update_after_op", upd_cyc - lop_cyc, 1);
        base = total_strobes();
        press(1'b1, 1'b0);
        chk("s2_leds_wrap", state_leds, 4'b0001);
        chk("s2_disp_wrap", display_sel, 1'b0);
        chk("s2_wrap_no_strobe", total_strobes() - base, 0);

        // 3: bouncing enter, then held
        do_reset();
        base_la = n_la; base = total_strobes();
        repeat (3) begin
            enter = 1'b1; tick(2);
            enter = 1'b0; tick(2);
        end
        enter = 1'b1; tick(15);
        enter = 1'b0; tick(10);
        chk("s3_load_a_cnt", n_la - base_la, 1);
        chk("s3_total_strobes", total_strobes() - base, 1);
        chk("s3_leds", state_leds, 4'b0010);

        // 4: undo walking back from WAIT_OP
        do_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("s4_leds_op", state_leds, 4'b0100);
        base = total_strobes();
        press(1'b0, 1'b1);
        chk("s4_leds_undo1", state_leds, 4'b0010);
        press(1'b0, 1'b1);
        chk("s4_leds_undo2", state_leds, 4'b0001);
        press(1'b0, 1'b1);
        chk("s4_leds_undo3", state_leds, 4'b0001);
        chk("s4_no_strobe", total_strobes() - base, 0);

        // 5: simultaneous enter and undo
        do_reset();
        press(1'b1, 1'b0);
        base = total_strobes();
        press(1'b1, 1'b1);
        chk("s5_leds", state_leds, 4'b0010);
        chk("s5_no_strobe", total_strobes() - base, 0);

        // 6: reset in the middle of an enter debounce
        do_reset();
        press(1'b1, 1'b0);
        enter = 1'b1;
        tick(2);
        rst_n = 1'b0;
        enter = 1'b0;
        #1;
        chk("s6_reset_leds", state_leds, 4'b0001);
        chk("s6_reset_strobes_disp", {load_A, load_B, load_Op, updateRes, display_sel}, 5'b0);
        tick(2);
        rst_n = 1'b1;
        base = total_strobes();
        tick(20);
        chk("s6_no_strobe", total_strobes() - base, 0);
        chk("s6_leds", state_leds, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
